controle_varredura_163: RTL and testbench

//   Moore control unit that sequences an external 3-bit 74163-style counter (contador_163) used as a

---
 rtl/controle_varredura_163_pkg.sv | 62 ++++++
 rtl/controle_varredura_163_timeout.sv | 25 ++
 rtl/controle_varredura_163.sv | 110 +++++++++++
 tb/tb_controle_varredura_163.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_varredura_163_pkg.sv
// Shared state codes and output decode for the 74163 sweep controller.
// Codes are fixed 4-bit values so db_estado stays stable across revisions.
package controle_varredura_163_pkg;

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] PREPARA     = 4'd1;
    localparam logic [3:0] CARREGA     = 4'd2;
    localparam logic [3:0] ESPERA      = 4'd3;
    localparam logic [3:0] REGISTRA    = 4'd4;
    localparam logic [3:0] COMPARA     = 4'd5;
    localparam logic [3:0] PROXIMO     = 4'd6;
    localparam logic [3:0] FIM_ACERTO  = 4'd7;
    localparam logic [3:0] FIM_ERRO    = 4'd8;
    localparam logic [3:0] FIM_TIMEOUT = 4'd9;

    typedef struct packed {
        logic clr_n;
        logic ld_n;
        logic ent;
        logic enp;
        logic zera_reg;
        logic registra;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctrl_t;

    function automatic ctrl_t decodifica(input logic [3:0] estado);
        ctrl_t c;
        c = '0;
        c.clr_n = 1'b1;
        c.ld_n  = 1'b1;
        unique case (1'b1)
            (estado == PREPARA): begin
                c.clr_n    = 1'b0;
                c.zera_reg = 1'b1;
            end
            (estado == CARREGA):  c.ld_n = 1'b0;
            (estado == REGISTRA): c.registra = 1'b1;
            (estado == PROXIMO): begin
                c.ent = 1'b1;
                c.enp = 1'b1;
            end
            (estado == FIM_ACERTO): begin
                c.pronto  = 1'b1;
                c.acertou = 1'b1;
            end
            (estado == FIM_ERRO): begin
                c.pronto = 1'b1;
                c.errou  = 1'b1;
            end
            (estado == FIM_TIMEOUT): begin
                c.pronto  = 1'b1;
                c.timeout = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/controle_varredura_163_timeout.sv
// Saturating wait timer for the ESPERA state.
// fim rises when the count reaches M-1 and the count then holds there.
module contador_timeout #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(M);

    logic [W-1:0] cont;

    assign fim = (cont == W'(M - 1));

    always_ff @(posedge clock) begin
        if (zera)
            cont <= '0;
        else if (conta && !fim)
            cont <= cont + 1'b1;
    end

endmodule

// File: rtl/controle_varredura_163.sv
// Moore controller driving an external 74163 counter as the round address.
// Sequences clear/load, waits for moves, strobes the register and checks matches.
module controle_varredura_163
    import controle_varredura_163_pkg::*;
#(
    parameter logic [2:0] START_ADDR     = 3'd0,
    parameter logic [2:0] END_ADDR       = 3'd7,
    parameter int         TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic [2:0] cnt_q,
    output logic       cnt_clr_n,
    output logic       cnt_ld_n,
    output logic       cnt_ent,
    output logic       cnt_enp,
    output logic [2:0] cnt_d,
    output logic       zera_reg,
    output logic       registra,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    logic [3:0] estado;
    logic [3:0] prox;
    logic       fim_espera;
    logic       zera_timer;
    logic       fim_any;
    ctrl_t      c;

    assign zera_timer = !clr
                      || (estado == PREPARA)
                      || (estado == REGISTRA)
                      || (estado == PROXIMO);

    contador_timeout #(
        .M(TIMEOUT_CYCLES)
    ) u_timer (
        .clock(clock),
        .zera (zera_timer),
        .conta(estado == ESPERA),
        .fim  (fim_espera)
    );

    assign fim_any = (estado == FIM_ACERTO)
                   || (estado == FIM_ERRO)
                   || (estado == FIM_TIMEOUT);

    always_comb begin
        prox = INICIAL;
        unique case (1'b1)
            (estado == INICIAL):
                prox = iniciar ? PREPARA : INICIAL;
            (estado == PREPARA):  prox = CARREGA;
            (estado == CARREGA):  prox = ESPERA;
            (estado == ESPERA): begin
                // a move on the expiry cycle still counts
                if (jogada)
                    prox = REGISTRA;
                else if (fim_espera)
                    prox = FIM_TIMEOUT;
                else
                    prox = ESPERA;
            end
            (estado == REGISTRA): prox = COMPARA;
            (estado == COMPARA): begin
                if (!igual)
                    prox = FIM_ERRO;
                else if (cnt_q == END_ADDR)
                    prox = FIM_ACERTO;
                else
                    prox = PROXIMO;
            end
            (estado == PROXIMO):  prox = ESPERA;
            fim_any:
                prox = iniciar ? PREPARA : estado;
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clr)
            estado <= INICIAL;
        else
            estado <= prox;
    end

    assign c = decodifica(estado);

    // counter clears in the same cycle the controller is reset
    assign cnt_clr_n = clr & c.clr_n;
    assign cnt_ld_n  = c.ld_n;
    assign cnt_ent   = c.ent;
    assign cnt_enp   = c.enp;
    assign cnt_d     = START_ADDR;
    assign zera_reg  = c.zera_reg;
    assign registra  = c.registra;
    assign pronto    = c.pronto;
    assign acertou   = c.acertou;
    assign errou     = c.errou;
    assign timeout   = c.timeout;
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_varredura_163.sv
// Randomized bench for controle_varredura_163 with behavioural 74163 models.
// Two instances cover a straight 0..7 sweep and a wrapping 6..1 sweep.
module tb_controle_varredura_163;

    localparam int M = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clr, iniciar, jogada, igual;

    logic [2:0] a_q, a_d, b_q, b_d;
    logic [3:0] a_db, b_db;
    logic a_clr_n, a_ld_n, a_ent, a_enp, a_zera, a_reg;
    logic a_pronto, a_hit, a_err, a_to;
    logic b_clr_n, b_ld_n, b_ent, b_enp, b_zera, b_reg;
    logic b_pronto, b_hit, b_err, b_to;

    controle_varredura_163 #(
        .START_ADDR(3'd0), .END_ADDR(3'd7), .TIMEOUT_CYCLES(M)
    ) dut_a (
        .clock(clock), .clr(clr), .iniciar(iniciar),
        .jogada(jogada), .igual(igual), .cnt_q(a_q),
        .cnt_clr_n(a_clr_n), .cnt_ld_n(a_ld_n),
        .cnt_ent(a_ent), .cnt_enp(a_enp), .cnt_d(a_d),
        .zera_reg(a_zera), .registra(a_reg),
        .pronto(a_pronto), .acertou(a_hit),
        .errou(a_err), .timeout(a_to), .db_estado(a_db)
    );

    controle_varredura_163 #(
        .START_ADDR(3'd6), .END_ADDR(3'd1), .TIMEOUT_CYCLES(M)
    ) dut_b (
        .clock(clock), .clr(clr), .iniciar(iniciar),
        .jogada(jogada), .igual(igual), .cnt_q(b_q),
        .cnt_clr_n(b_clr_n), .cnt_ld_n(b_ld_n),
        .cnt_ent(b_ent), .cnt_enp(b_enp), .cnt_d(b_d),
        .zera_reg(b_zera), .registra(b_reg),
        .pronto(b_pronto), .acertou(b_hit),
        .errou(b_err), .timeout(b_to), .db_estado(b_db)
    );

    // external 74163 counters
    always @(posedge clock) begin
        if (!a_clr_n)            a_q <= 3'd0;
        else if (!a_ld_n)        a_q <= a_d;
        else if (a_ent && a_enp) a_q <= a_q + 3'd1;
    end

    always @(posedge clock) begin
        if (!b_clr_n)            b_q <= 3'd0;
        else if (!b_ld_n)        b_q <= b_d;
        else if (b_ent && b_enp) b_q <= b_q + 3'd1;
    end

    bit sel;
    logic [3:0] o_db;
    logic [2:0] o_q, o_d;
    logic o_clr_n, o_ld_n, o_inc, o_zera, o_reg;
    logic o_pronto, o_hit, o_err, o_to;

    assign o_db     = sel ? b_db : a_db;
    assign o_q      = sel ? b_q : a_q;
    assign o_d      = sel ? b_d : a_d;
    assign o_clr_n  = sel ? b_clr_n : a_clr_n;
    assign o_ld_n   = sel ? b_ld_n : a_ld_n;
    assign o_inc    = sel ? (b_ent & b_enp) : (a_ent & a_enp);
    assign o_zera   = sel ? b_zera : a_zera;
    assign o_reg    = sel ? b_reg : a_reg;
    assign o_pronto = sel ? b_pronto : a_pronto;
    assign o_hit    = sel ? b_hit : a_hit;
    assign o_err    = sel ? b_err : a_err;
    assign o_to     = sel ? b_to : a_to;

    int total = 0;
    int bad = 0;
    int regs = 0;
    int incs = 0;

    // reference: address of the k-th move and sweep length
    function automatic logic [2:0] addr_at(input bit b, input int k);
        int s;
        s = b ? 6 : 0;
        return 3'((s + k) % 8);
    endfunction

    function automatic int sweep_len(input bit b);
        int s, e;
        s = b ? 6 : 0;
        e = b ? 1 : 7;
        return ((e - s + 8) % 8) + 1;
    endfunction

    task automatic cyc();
        @(negedge clock);
        if (o_reg === 1'b1) regs++;
        if (o_inc === 1'b1) incs++;
    endtask

    task automatic do_clr();
        clr = 1'b0;
        iniciar = 1'b0;
        jogada = 1'b0;
        cyc();
        cyc();
        clr = 1'b1;
        regs = 0;
        incs = 0;
    endtask

    task automatic start_round();
        logic [2:0] s;
        s = addr_at(sel, 0);
        iniciar = 1'b1;
        cyc();
        total++;
        if ({o_db, o_clr_n, o_zera, o_pronto, o_hit, o_err, o_to}
            !== {4'd1, 1'b0, 1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL prepara got=%b want=%b",
                {o_db, o_clr_n, o_zera, o_pronto, o_hit, o_err, o_to},
                {4'd1, 1'b0, 1'b1, 4'b0000});
        end
        iniciar = 1'b0;
        cyc();
        total++;
        if ({o_db, o_ld_n, o_d} !== {4'd2, 1'b0, s}) begin
            bad++;
            $display("FAIL carrega got=%b want=%b",
                {o_db, o_ld_n, o_d}, {4'd2, 1'b0, s});
        end
        cyc();
        total++;
        if ({o_db, o_q} !== {4'd3, s}) begin
            bad++;
            $display("FAIL espera_entry got=%b want=%b",
                {o_db, o_q}, {4'd3, s});
        end
    endtask

    task automatic play_move(input int k, input bit ok, input bit last);
        int gap;
        logic [2:0] ad;
        logic [3:0] want;
        ad = addr_at(sel, k);
        gap = $urandom_range(0, M - 1);
        jogada = 1'b0;
        repeat (gap) begin
            igual = 1'($urandom_range(0, 1));
            cyc();
        end
        total++;
        if ({o_db, o_q} !== {4'd3, ad}) begin
            bad++;
            $display("FAIL wait k=%0d got=%b want=%b",
                k, {o_db, o_q}, {4'd3, ad});
        end
        jogada = 1'b1;
        cyc();
        total++;
        if ({o_db, o_reg} !== {4'd4, 1'b1}) begin
            bad++;
            $display("FAIL registra k=%0d got=%b want=%b",
                k, {o_db, o_reg}, {4'd4, 1'b1});
        end
        jogada = 1'($urandom_range(0, 1));
        igual = 1'($urandom_range(0, 1));
        cyc();
        total++;
        if ({o_db, o_q} !== {4'd5, ad}) begin
            bad++;
            $display("FAIL compara k=%0d got=%b want=%b",
                k, {o_db, o_q}, {4'd5, ad});
        end
        igual = ok;
        jogada = 1'($urandom_range(0, 1));
        cyc();
        want = !ok ? 4'd8 : (last ? 4'd7 : 4'd6);
        total++;
        if (o_db !== want) begin
            bad++;
            $display("FAIL decide k=%0d got=%0d want=%0d",
                k, o_db, want);
        end
        if (want == 4'd6) begin
            jogada = 1'($urandom_range(0, 1));
            cyc();
        end
        jogada = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_clr();
        start_round();
        clr = 1'b0;
        iniciar = 1'b1;
        #1;
        total++;
        if (a_clr_n !== 1'b0) begin
            bad++;
            $display("FAIL clr_comb got=%b want=0", a_clr_n);
        end
        repeat (2) begin
            cyc();
            total++;
            if ({a_db, a_clr_n, a_pronto, a_hit, a_err, a_to}
                !== 9'b0) begin
                bad++;
                $display("FAIL clr_hold got=%b want=0",
                    {a_db, a_clr_n, a_pronto, a_hit, a_err, a_to});
            end
        end
        clr = 1'b1;
        iniciar = 1'b0;
        repeat (3) cyc();
        total++;
        if ({a_db, a_clr_n, a_q} !== {4'd0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL idle got=%b want=%b",
                {a_db, a_clr_n, a_q}, {4'd0, 1'b1, 3'd0});
        end
    endtask

    task automatic test_sweep();
        int n;
        sel = 1'b0;
        n = sweep_len(sel);
        do_clr();
        start_round();
        for (int k = 0; k < n; k++)
            play_move(k, 1'b1, k == n - 1);
        total++;
        if ({o_pronto, o_hit, o_err, o_to} !== 4'b1100) begin
            bad++;
            $display("FAIL sweep_flags got=%b want=1100",
                {o_pronto, o_hit, o_err, o_to});
        end
        total++;
        if (regs != n || incs != n - 1) begin
            bad++;
            $display("FAIL sweep_counts got=%0d/%0d want=%0d/%0d",
                regs, incs, n, n - 1);
        end
        repeat (3) begin
            jogada = 1'($urandom_range(0, 1));
            cyc();
        end
        jogada = 1'b0;
        total++;
        if ({o_db, o_q} !== {4'd7, 3'd7} || incs != n - 1) begin
            bad++;
            $display("FAIL sweep_hold got=%b/%0d want=%b/%0d",
                {o_db, o_q}, incs, {4'd7, 3'd7}, n - 1);
        end
    endtask

    task automatic test_error(input int e);
        sel = 1'b0;
        do_clr();
        start_round();
        for (int k = 0; k <= e; k++)
            play_move(k, k != e, 1'b0);
        total++;
        if ({o_db, o_pronto, o_hit, o_err, o_to, o_q}
            !== {4'd8, 4'b1010, addr_at(sel, e)}) begin
            bad++;
            $display("FAIL error e=%0d got=%b want=%b", e,
                {o_db, o_pronto, o_hit, o_err, o_to, o_q},
                {4'd8, 4'b1010, addr_at(sel, e)});
        end
    endtask

    task automatic test_timeout();
        int n, pre;
        sel = 1'b0;
        do_clr();
        start_round();
        pre = $urandom_range(0, 3);
        for (int k = 0; k < pre; k++)
            play_move(k, 1'b1, 1'b0);
        n = 0;
        jogada = 1'b0;
        while (o_db == 4'd3 && n < 50) begin
            cyc();
            n++;
        end
        total++;
        if (n != M || o_db !== 4'd9) begin
            bad++;
            $display("FAIL timeout_len got=%0d/%0d want=%0d/9",
                n, o_db, M);
        end
        jogada = 1'b1;
        cyc();
        jogada = 1'b0;
        total++;
        if ({o_db, o_pronto, o_hit, o_err, o_to}
            !== {4'd9, 4'b1001}) begin
            bad++;
            $display("FAIL timeout_flags got=%b want=%b",
                {o_db, o_pronto, o_hit, o_err, o_to},
                {4'd9, 4'b1001});
        end
        do_clr();
        start_round();
        repeat (M - 1) cyc();
        jogada = 1'b1;
        cyc();
        jogada = 1'b0;
        total++;
        if (o_db !== 4'd4) begin
            bad++;
            $display("FAIL timeout_race got=%0d want=4", o_db);
        end
    endtask

    task automatic test_wrap();
        int n;
        sel = 1'b1;
        n = sweep_len(sel);
        do_clr();
        start_round();
        for (int k = 0; k < n; k++)
            play_move(k, 1'b1, k == n - 1);
        total++;
        if ({o_db, o_hit, o_q, incs} !== {4'd7, 1'b1, 3'd1, 32'd3}) begin
            bad++;
            $display("FAIL wrap got=%0d/%b/%0d/%0d want=7/1/1/3",
                o_db, o_hit, o_q, incs);
        end
    endtask

    task automatic test_restart();
        test_error($urandom_range(0, 7));
        start_round();
        iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        total++;
        if ({o_db, o_q} !== {4'd3, 3'd0}) begin
            bad++;
            $display("FAIL restart_ignore got=%b want=%b",
                {o_db, o_q}, {4'd3, 3'd0});
        end
    endtask

    task automatic test_random();
        int n, e;
        for (int r = 0; r < 6; r++) begin
            sel = 1'($urandom_range(0, 1));
            n = sweep_len(sel);
            e = $urandom_range(0, n);
            do_clr();
            start_round();
            for (int k = 0; k < n && k <= e; k++)
                play_move(k, k != e, k == n - 1);
            total++;
            if (e == n) begin
                if ({o_db, o_q, regs, incs} !==
                    {4'd7, addr_at(sel, n - 1), n, n - 1}) begin
                    bad++;
                    $display("FAIL rnd_hit r=%0d got=%0d/%0d/%0d/%0d",
                        r, o_db, o_q, regs, incs);
                end
            end else begin
                if ({o_db, o_q, regs, incs} !==
                    {4'd8, addr_at(sel, e), e + 1, e}) begin
                    bad++;
                    $display("FAIL rnd_err r=%0d got=%0d/%0d/%0d/%0d",
                        r, o_db, o_q, regs, incs);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        clr = 1'b0;
        iniciar = 1'b0;
        jogada = 1'b0;
        igual = 1'b0;
        cyc();
        total++;
        if ({a_db, a_clr_n, a_q} !== {4'd0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL por got=%b want=%b",
                {a_db, a_clr_n, a_q}, {4'd0, 1'b0, 3'd0});
        end
        test_reset();
        test_sweep();
        test_error(3);
        test_error($urandom_range(0, 7));
        test_timeout();
        test_wrap();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
